// File: rtl/wide_uart_pkg.sv
// Shared types and defaults for the wide UART receiver.
package wide_uart_pkg;

  localparam int unsigned DefaultClksPerBit = 868;
  localparam int unsigned DefaultWordBytes  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchronises the serial line and emits one byte per good frame.
module uart_byte_rx
  import wide_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam logic [15:0] HalfCnt = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BitCnt  = 16'(CLKS_PER_BIT - 1);

  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rx_meta_q, rx_sync_q;

  // Line synchroniser idles at 1 so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_q == BitCnt) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == BitCnt) begin
          cnt_d   = '0;
          valid_d = rx_sync_q;
          ferr_d  = !rx_sync_q;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/wide_uart_rx.sv
// UART receiver assembling WORD_BYTES little-endian bytes into an AXI-Stream word.
module wide_uart_rx
  import wide_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned WORD_BYTES   = DefaultWordBytes
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    RsRx,
  output logic [8*WORD_BYTES-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    frame_err,
  output logic                    overrun
);

  localparam int unsigned     IdxW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_BYTES - 1);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assert asynchronously, release two clocks after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       byte_ferr;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (RsRx),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (byte_ferr)
  );

  logic [IdxW-1:0]         idx_q, idx_d;
  logic [8*WORD_BYTES-1:0] acc_q, acc_d;
  logic [8*WORD_BYTES-1:0] tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    ferr_q, ferr_d;
  logic                    ovr_q, ovr_d;
  logic                    word_done;

  always_comb begin
    idx_d     = idx_q;
    acc_d     = acc_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    ferr_d    = byte_ferr;
    ovr_d     = 1'b0;
    word_done = 1'b0;

    // A bad stop bit abandons the partial word; later bytes restart at byte 0.
    if (byte_ferr) begin
      idx_d = '0;
    end else if (byte_valid) begin
      acc_d[8*idx_q +: 8] = rx_byte;
      if (idx_q == LastIdx) begin
        idx_d     = '0;
        word_done = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

    if (word_done) begin
      if (!tvalid_q || m_axis_tready) begin
        tdata_d  = acc_d;
        tvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_wide_uart_rx.sv
// Directed bench for wide_uart_rx at 16 clocks per bit, 8-byte words.
module tb_wide_uart_rx;

  localparam int unsigned Cpb = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RsRx = 1'b1;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        frame_err;
  logic        overrun;

  always #5 clk = ~clk;

  wide_uart_rx #(
    .CLKS_PER_BIT(Cpb),
    .WORD_BYTES  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .RsRx         (RsRx),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned hs_cnt   = 0;
  int unsigned ferr_cnt = 0;
  int unsigned ovr_cnt  = 0;
  logic [63:0] last_word = '0;

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      hs_cnt    <= hs_cnt + 1;
      last_word <= m_axis_tdata;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
    else n_pass++;
  endtask

  // A bad stop bit is held low only past its centre so the tail is not taken as a start.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    RsRx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    RsRx = stop;
    repeat (stop ? Cpb : 11) @(negedge clk);
    RsRx = 1'b1;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 0; i < 8; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        glitch;
    int unsigned pre_n;
    logic [31:0] pre;
    logic [63:0] word;
    int unsigned exp_words;
    int unsigned exp_ferr;
    logic [63:0] exp_word;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int unsigned hs0, fe0, ov0;

    vecs[0] = '{"plain", 1'b0, 0, 32'h0, 64'hfeedfacedeadbeef, 1, 0, 64'hfeedfacedeadbeef};
    vecs[1] = '{"glitch", 1'b1, 0, 32'h0, 64'hfeedfacedeadbeef, 1, 0, 64'hfeedfacedeadbeef};
    vecs[2] = '{"stoperr", 1'b0, 4, 32'h44332211, 64'h0807060504030201, 1, 1,
                64'h0807060504030201};

    // Reset held low: all outputs zero
    cycles(10);
    check("rst_tdata", m_axis_tdata, 64'h0);
    check("rst_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
    check("rst_ferr", {63'h0, frame_err}, 64'h0);
    check("rst_ovr", {63'h0, overrun}, 64'h0);
    rst = 1'b1;
    cycles(200);
    check("idle_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
    check("idle_hs", 64'(hs_cnt), 64'h0);
    check("idle_ferr", 64'(ferr_cnt), 64'h0);
    check("idle_ovr", 64'(ovr_cnt), 64'h0);

    foreach (vecs[v]) begin
      hs0 = hs_cnt;
      fe0 = ferr_cnt;
      ov0 = ovr_cnt;
      if (vecs[v].glitch) begin
        @(negedge clk);
        RsRx = 1'b0;
        repeat (5) @(negedge clk);
        RsRx = 1'b1;
        repeat (40) @(negedge clk);
      end
      for (int i = 0; i < int'(vecs[v].pre_n); i++)
        send_byte(vecs[v].pre[8*i +: 8], (i != int'(vecs[v].pre_n) - 1));
      send_word(vecs[v].word);
      cycles(20);
      check({vecs[v].name, "_words"}, 64'(hs_cnt - hs0), 64'(vecs[v].exp_words));
      check({vecs[v].name, "_data"}, last_word, vecs[v].exp_word);
      check({vecs[v].name, "_ferr"}, 64'(ferr_cnt - fe0), 64'(vecs[v].exp_ferr));
      check({vecs[v].name, "_ovr"}, 64'(ovr_cnt - ov0), 64'h0);
    end

    // Backpressure: second word dropped with an overrun pulse
    hs0 = hs_cnt;
    ov0 = ovr_cnt;
    @(posedge clk);
    #1 m_axis_tready = 1'b0;
    send_word(64'hfeedfacedeadbeef);
    send_word(64'h0807060504030201);
    cycles(20);
    check("bp_tvalid", {63'h0, m_axis_tvalid}, 64'h1);
    check("bp_tdata", m_axis_tdata, 64'hfeedfacedeadbeef);
    check("bp_ovr", 64'(ovr_cnt - ov0), 64'h1);
    m_axis_tready = 1'b1;
    cycles(1);
    check("bp_tvalid_clr", {63'h0, m_axis_tvalid}, 64'h0);
    check("bp_hs", 64'(hs_cnt - hs0), 64'h1);
    check("bp_hs_data", last_word, 64'hfeedfacedeadbeef);

    // Reset in the middle of the fifth byte
    hs0 = hs_cnt;
    for (int i = 0; i < 4; i++) send_byte(8'h11 * 8'(i + 1), 1'b1);
    @(negedge clk);
    RsRx = 1'b0;
    repeat (Cpb * 4) @(negedge clk);
    rst  = 1'b0;
    RsRx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    cycles(20);
    check("rst_mid_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
    send_word(64'h0807060504030201);
    cycles(20);
    check("rst_mid_words", 64'(hs_cnt - hs0), 64'h1);
    check("rst_mid_data", last_word, 64'h0807060504030201);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
